// File: rtl/hilo_pkg.sv
// Shared types for the HI/LO writeback pipeline: the stage entry record and the data width.
`ifndef W_DATA
`define W_DATA 32
`endif

package hilo_pkg;

  localparam int unsigned HILO_DATA_W = `W_DATA;

  typedef struct packed {
    logic                   valid;
    logic                   hi_we;
    logic                   lo_we;
    logic [HILO_DATA_W-1:0] hi;
    logic [HILO_DATA_W-1:0] lo;
  } hilo_entry_t;

  localparam hilo_entry_t HILO_EMPTY = '0;

  function automatic logic hilo_writes_any(input hilo_entry_t e);
    return e.valid & (e.hi_we | e.lo_we);
  endfunction

endpackage

// File: rtl/hilo_pipe_stage_reg.sv
// One HI/LO pipeline stage register: stall hold, kill (wins over hold), async active-low reset.
module hilo_stage_reg
  import hilo_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        kill,
  input  hilo_entry_t d,
  output hilo_entry_t q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= HILO_EMPTY;
    end else if (kill) begin
      q.valid <= 1'b0;
      q.hi_we <= 1'b0;
      q.lo_we <= 1'b0;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/hilo_pipe.sv
// HI/LO MEM/WB pipeline with commit at WB and youngest-first forwarding to EX.
// Optional macro HILO_COMMIT_CNT_EN adds the commit_cnt output.
module hilo_pipe
  import hilo_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic              ex_hi_we,
  input  logic              ex_lo_we,
  input  logic [DATA_W-1:0] ex_hi,
  input  logic [DATA_W-1:0] ex_lo,
  output logic [DATA_W-1:0] fwd_hi,
  output logic [DATA_W-1:0] fwd_lo,
  output logic [DATA_W-1:0] arch_hi,
  output logic [DATA_W-1:0] arch_lo,
  output logic              pending
`ifdef HILO_COMMIT_CNT_EN
  ,
  output logic [31:0]       commit_cnt
`endif
);

  hilo_entry_t ex_e;
  hilo_entry_t m_q;
  hilo_entry_t w_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic advance;
  logic commit_hi;
  logic commit_lo;

  always_comb begin
    ex_e       = HILO_EMPTY;
    ex_e.valid = ex_valid;
    ex_e.hi_we = ex_valid & ex_hi_we;
    ex_e.lo_we = ex_valid & ex_lo_we;
    ex_e.hi    = ex_hi;
    ex_e.lo    = ex_lo;
  end

  hilo_stage_reg u_stage_m (
    .clk  (clk),
    .rst  (rst),
    .hold (reg_stall),
    .kill (flush),
    .d    (ex_e),
    .q    (m_q)
  );

  hilo_stage_reg u_stage_w (
    .clk  (clk),
    .rst  (rst),
    .hold (reg_stall),
    .kill (flush),
    .d    (m_q),
    .q    (w_q)
  );

  // The WB entry is older than a faulting MEM instruction, so it still commits on flush.
  assign advance   = ~reg_stall | flush;
  assign commit_hi = advance & w_q.valid & w_q.hi_we;
  assign commit_lo = advance & w_q.valid & w_q.lo_we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (commit_hi) hi_q <= w_q.hi;
      if (commit_lo) lo_q <= w_q.lo;
    end
  end

`ifdef HILO_COMMIT_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      commit_cnt <= '0;
    end else if (commit_hi | commit_lo) begin
      commit_cnt <= commit_cnt + 32'd1;
    end
  end
`endif

  always_comb begin
    fwd_hi = hi_q;
    if (m_q.valid & m_q.hi_we)      fwd_hi = m_q.hi;
    else if (w_q.valid & w_q.hi_we) fwd_hi = w_q.hi;
  end

  always_comb begin
    fwd_lo = lo_q;
    if (m_q.valid & m_q.lo_we)      fwd_lo = m_q.lo;
    else if (w_q.valid & w_q.lo_we) fwd_lo = w_q.lo;
  end

  assign arch_hi = hi_q;
  assign arch_lo = lo_q;
  assign pending = hilo_writes_any(m_q) | hilo_writes_any(w_q);

endmodule

// File: tb/tb_hilo_pipe.sv
// Directed vector bench for hilo_pipe: commit latency, priority, stall, flush, split writes, async reset.
`timescale 1ns/1ps
module tb_hilo_pipe;

  typedef struct {
    logic        stall;
    logic        flush;
    logic        ev;
    logic        hwe;
    logic        lwe;
    logic [31:0] eh;
    logic [31:0] el;
    logic [31:0] f_hi;
    logic [31:0] f_lo;
    logic [31:0] a_hi;
    logic [31:0] a_lo;
    logic        pend;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_stall, flush, ex_valid, ex_hi_we, ex_lo_we;
  logic [31:0] ex_hi, ex_lo;
  logic [31:0] fwd_hi, fwd_lo, arch_hi, arch_lo;
  logic        pending;
`ifdef HILO_COMMIT_CNT_EN
  logic [31:0] commit_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[25];

  hilo_pipe #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .reg_stall (reg_stall),
    .flush     (flush),
    .ex_valid  (ex_valid),
    .ex_hi_we  (ex_hi_we),
    .ex_lo_we  (ex_lo_we),
    .ex_hi     (ex_hi),
    .ex_lo     (ex_lo),
    .fwd_hi    (fwd_hi),
    .fwd_lo    (fwd_lo),
    .arch_hi   (arch_hi),
    .arch_lo   (arch_lo),
    .pending   (pending)
`ifdef HILO_COMMIT_CNT_EN
    ,
    .commit_cnt(commit_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic s, input logic f, input logic v, input logic hw,
                              input logic lw, input logic [31:0] eh, input logic [31:0] el,
                              input logic [31:0] fh, input logic [31:0] fl,
                              input logic [31:0] ah, input logic [31:0] al, input logic p);
    vec_t r;
    r.stall = s; r.flush = f; r.ev = v; r.hwe = hw; r.lwe = lw;
    r.eh = eh; r.el = el; r.f_hi = fh; r.f_lo = fl; r.a_hi = ah; r.a_lo = al; r.pend = p;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic f, input logic v, input logic hw,
                       input logic lw, input logic [31:0] eh, input logic [31:0] el);
    reg_stall = s; flush = f; ex_valid = v; ex_hi_we = hw; ex_lo_we = lw; ex_hi = eh; ex_lo = el;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // stall flush ev hwe lwe  ex_hi ex_lo | fwd_hi fwd_lo arch_hi arch_lo pending
    tbl[0]  = mk(0,0,1,1,1, 32'h12345678, 32'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h0, 1);
    tbl[1]  = mk(0,0,0,0,0, 32'h0, 32'h0, 32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h0, 1);
    tbl[2]  = mk(0,0,0,0,0, 32'h0, 32'h0, 32'h12345678, 32'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0, 0);
    tbl[3]  = mk(0,0,1,1,0, 32'h1, 32'hDEAD, 32'h1, 32'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0, 1);
    tbl[4]  = mk(0,0,1,1,0, 32'h2, 32'h0, 32'h2, 32'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0, 1);
    tbl[5]  = mk(0,0,0,0,0, 32'h0, 32'h0, 32'h2, 32'h9ABCDEF0, 32'h1, 32'h9ABCDEF0, 1);
    tbl[6]  = mk(0,0,0,0,0, 32'h0, 32'h0, 32'h2, 32'h9ABCDEF0, 32'h2, 32'h9ABCDEF0, 0);
    tbl[7]  = mk(0,0,1,0,1, 32'hBEEF, 32'hAA, 32'h2, 32'hAA, 32'h2, 32'h9ABCDEF0, 1);
    tbl[8]  = mk(0,0,0,0,0, 32'h0, 32'h0, 32'h2, 32'hAA, 32'h2, 32'h9ABCDEF0, 1);
    tbl[9]  = mk(1,0,1,1,1, 32'h99, 32'h98, 32'h2, 32'hAA, 32'h2, 32'h9ABCDEF0, 1);
    tbl[10] = mk(1,0,1,1,1, 32'h99, 32'h98, 32'h2, 32'hAA, 32'h2, 32'h9ABCDEF0, 1);
    tbl[11] = mk(1,0,1,1,1, 32'h99, 32'h98, 32'h2, 32'hAA, 32'h2, 32'h9ABCDEF0, 1);
    tbl[12] = mk(1,0,1,1,1, 32'h99, 32'h98, 32'h2, 32'hAA, 32'h2, 32'h9ABCDEF0, 1);
    tbl[13] = mk(0,0,0,0,0, 32'h0, 32'h0, 32'h2, 32'hAA, 32'h2, 32'hAA, 0);
    tbl[14] = mk(0,0,1,1,0, 32'h5, 32'h0, 32'h5, 32'hAA, 32'h2, 32'hAA, 1);
    tbl[15] = mk(0,0,1,1,0, 32'h6, 32'h0, 32'h6, 32'hAA, 32'h2, 32'hAA, 1);
    tbl[16] = mk(1,1,1,1,0, 32'h7, 32'h0, 32'h5, 32'hAA, 32'h5, 32'hAA, 0);
    tbl[17] = mk(0,0,0,0,0, 32'h0, 32'h0, 32'h5, 32'hAA, 32'h5, 32'hAA, 0);
    tbl[18] = mk(0,0,0,0,0, 32'h0, 32'h0, 32'h5, 32'hAA, 32'h5, 32'hAA, 0);
    tbl[19] = mk(0,0,1,1,0, 32'hC, 32'h55, 32'hC, 32'hAA, 32'h5, 32'hAA, 1);
    tbl[20] = mk(0,0,1,0,1, 32'h66, 32'hD, 32'hC, 32'hD, 32'h5, 32'hAA, 1);
    tbl[21] = mk(0,0,0,0,0, 32'h0, 32'h0, 32'hC, 32'hD, 32'hC, 32'hAA, 1);
    tbl[22] = mk(0,0,0,0,0, 32'h0, 32'h0, 32'hC, 32'hD, 32'hC, 32'hD, 0);
    tbl[23] = mk(0,0,0,1,1, 32'h77, 32'h88, 32'hC, 32'hD, 32'hC, 32'hD, 0);
    tbl[24] = mk(0,0,0,0,0, 32'h0, 32'h0, 32'hC, 32'hD, 32'hC, 32'hD, 0);

    rst = 1'b0;
    drive(0,0,0,0,0, 32'h0, 32'h0);
    #12;
    check("reset_fwd_hi",  fwd_hi,  32'h0);
    check("reset_fwd_lo",  fwd_lo,  32'h0);
    check("reset_arch_hi", arch_hi, 32'h0);
    check("reset_arch_lo", arch_lo, 32'h0);
    check("reset_pending", {31'h0, pending}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      drive(tbl[i].stall, tbl[i].flush, tbl[i].ev, tbl[i].hwe, tbl[i].lwe, tbl[i].eh, tbl[i].el);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_fwd_hi", i),  fwd_hi,  tbl[i].f_hi);
      check($sformatf("v%0d_fwd_lo", i),  fwd_lo,  tbl[i].f_lo);
      check($sformatf("v%0d_arch_hi", i), arch_hi, tbl[i].a_hi);
      check($sformatf("v%0d_arch_lo", i), arch_lo, tbl[i].a_lo);
      check($sformatf("v%0d_pending", i), {31'h0, pending}, {31'h0, tbl[i].pend});
    end

`ifdef HILO_COMMIT_CNT_EN
    check("commit_cnt_after_table", commit_cnt, 32'd7);
`endif

    // Load both M and W, then drop reset between clock edges.
    @(negedge clk);
    drive(0,0,1,1,1, 32'h11, 32'h22);
    @(negedge clk);
    drive(0,0,1,1,1, 32'h33, 32'h44);
    @(posedge clk);
    #1;
    check("preload_fwd_hi",  fwd_hi, 32'h33);
    check("preload_pending", {31'h0, pending}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_fwd_hi",  fwd_hi,  32'h0);
    check("async_rst_fwd_lo",  fwd_lo,  32'h0);
    check("async_rst_arch_hi", arch_hi, 32'h0);
    check("async_rst_arch_lo", arch_lo, 32'h0);
    check("async_rst_pending", {31'h0, pending}, 32'h0);
`ifdef HILO_COMMIT_CNT_EN
    check("async_rst_commit_cnt", commit_cnt, 32'h0);
`endif
    @(negedge clk);
    drive(0,0,0,0,0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_arch_hi", arch_hi, 32'h0);
    check("post_rst_arch_lo", arch_lo, 32'h0);
    check("post_rst_pending", {31'h0, pending}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
